// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end stage of the MIPS core.
//
// Holds the PC, fetches one word at a time from instruction memory over a
// request/grant/response handshake, and hands each instruction with its PC
// to decode over a valid/ready handshake. A redirect from execute reloads the
// PC; a response already owed by memory for the old path is squashed.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   imem_req/imem_addr       fetch request and its address (= pc)
//   imem_gnt                 memory accepted the request this cycle
//   imem_rvalid/imem_rdata   one response per granted request
//   if_valid/if_ready        instruction handshake towards decode
//   if_instr/if_pc           registered instruction and its PC
//   if_pc_plus4              if_pc + 4 (wraps)
//   ins_opCode               if_instr[31:26] for the main control decoder
//   redirect/redirect_pc     new fetch target from execute
//   if_fault                 only with IF_ALIGN_FAULT_EN: misaligned redirect seen
//
// Build option IF_ALIGN_FAULT_EN: a misaligned redirect target raises if_fault
// and parks the stage in a non-fetching state until an aligned redirect.
// Without it the low two target bits are forced to zero.

module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic [5:0]        ins_opCode,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IF_ALIGN_FAULT_EN
  ,
  output logic              if_fault
`endif
);

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold
`ifdef IF_ALIGN_FAULT_EN
    ,
    StFault
`endif
  } ifStateT;

  ifStateT           stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic              dropQ, dropD;
  logic              validQ, validD;
  logic [31:0]       instrQ, instrD;
  logic [ADDR_W-1:0] ifPcQ, ifPcD;
`ifdef IF_ALIGN_FAULT_EN
  logic              faultQ, faultD;
  logic              misaligned;
`endif

  logic [ADDR_W-1:0] redirTarget;
  logic              stillPending;

  assign redirTarget = redirect_pc & ~ADDR_W'(3);
`ifdef IF_ALIGN_FAULT_EN
  assign misaligned  = (redirect_pc[1:0] != 2'b00);
`endif

  // A granted request whose response has not arrived by the end of this cycle.
  // A redirect must keep waiting for it (and drop it) so that memory never sees
  // a second outstanding request.
  always_comb begin
    stillPending = ((stateQ == StFetch) && imem_gnt) ||
                   ((stateQ == StWait) && !imem_rvalid);
`ifdef IF_ALIGN_FAULT_EN
    if ((stateQ == StFault) && dropQ && !imem_rvalid) begin
      stillPending = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StFetch;
      pcQ    <= RESET_PC;
      dropQ  <= 1'b0;
      validQ <= 1'b0;
      instrQ <= '0;
      ifPcQ  <= RESET_PC;
`ifdef IF_ALIGN_FAULT_EN
      faultQ <= 1'b0;
`endif
    end else begin
      stateQ <= stateD;
      pcQ    <= pcD;
      dropQ  <= dropD;
      validQ <= validD;
      instrQ <= instrD;
      ifPcQ  <= ifPcD;
`ifdef IF_ALIGN_FAULT_EN
      faultQ <= faultD;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    pcD    = pcQ;
    dropD  = dropQ;
    validD = validQ;
    instrD = instrQ;
    ifPcD  = ifPcQ;
`ifdef IF_ALIGN_FAULT_EN
    faultD = faultQ;
`endif

    if (redirect) begin
      // Overrides increment in every state; a transfer in HOLD this cycle still
      // completes on the decode side, only the PC source changes.
      validD = 1'b0;
      pcD    = redirTarget;
      dropD  = stillPending;
      stateD = stillPending ? StWait : StFetch;
`ifdef IF_ALIGN_FAULT_EN
      faultD = 1'b0;
      if (misaligned) begin
        pcD    = redirect_pc;
        faultD = 1'b1;
        stateD = StFault;
      end
`endif
    end else begin
      case (stateQ)
        StFetch: begin
          if (imem_gnt) begin
            stateD = StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (dropQ) begin
              dropD  = 1'b0;
              stateD = StFetch;
            end else begin
              instrD = imem_rdata;
              ifPcD  = pcQ;
              validD = 1'b1;
              stateD = StHold;
            end
          end
        end
        StHold: begin
          if (if_ready) begin
            pcD    = pcQ + ADDR_W'(3'd4);
            validD = 1'b0;
            stateD = StFetch;
          end
        end
`ifdef IF_ALIGN_FAULT_EN
        StFault: begin
          if (imem_rvalid) begin
            dropD = 1'b0;
          end
        end
`endif
        default: stateD = StFetch;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    imem_req    = (stateQ == StFetch) && !rst;
    imem_addr   = pcQ;
    if_valid    = validQ;
    if_instr    = instrQ;
    if_pc       = ifPcQ;
    if_pc_plus4 = ifPcQ + ADDR_W'(3'd4);
    ins_opCode  = instrQ[31:26];
`ifdef IF_ALIGN_FAULT_EN
    if_fault    = faultQ;
`endif
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [5:0]  ins_opCode;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef IF_ALIGN_FAULT_EN
  logic        if_fault;
`endif

  instruction_fetch #(
    .ADDR_W  (32),
    .RESET_PC(RPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_plus4(if_pc_plus4),
    .ins_opCode (ins_opCode),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
`ifdef IF_ALIGN_FAULT_EN
    ,
    .if_fault   (if_fault)
`endif
  );

  always #5 clk = ~clk;

  // Program image: word at address 0 is 0x8C220004 (lw, opcode 100011).
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h8C22_0004 ^ (a * 32'h04C1_1DB7);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stimulus controls
  bit          rstReq = 1'b1;
  bit          redirReq = 1'b0;
  logic [31:0] redirTarget = '0;
  int          readyMode = 1;  // 0 random, 1 high, 2 low
  int          gntPct = 100;
  int          latMin = 1;
  int          latMax = 1;

  // Memory model
  bit          pend = 1'b0;
  logic [31:0] pendAddr = '0;
  int          pendCnt = 0;
  bit          gntNow = 1'b0;
  bit          forceDead = 1'b0;
  logic [31:0] gntLog[$];

  // Reference model: PC of the next instruction decode should receive
  logic [31:0] expPc = RPC;
  logic [31:0] expQ[$];
  int          xfers = 0;

  task automatic cycle();
    @(posedge clk);
    #1;
    rst         = rstReq;
    redirect    = redirReq;
    redirect_pc = redirTarget;
    case (readyMode)
      0:       if_ready = 1'($urandom_range(1));
      1:       if_ready = 1'b1;
      default: if_ready = 1'b0;
    endcase
    #1;
    gntNow      = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      if (pendCnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = forceDead ? 32'hDEAD_BEEF : memWord(pendAddr);
        forceDead   = 1'b0;
        pend        = 1'b0;
      end else begin
        pendCnt--;
      end
    end
    if (rst) check32("req_in_reset", 32'(imem_req), 32'd0);
    imem_gnt = 1'b0;
    if (imem_req) begin
      check32("single_outstanding", 32'(pend), 32'd0);
      if (!pend && ($urandom_range(99) < 32'(gntPct))) begin
        imem_gnt = 1'b1;
        gntNow   = 1'b1;
        pend     = 1'b1;
        pendAddr = imem_addr;
        pendCnt  = int'($urandom_range(latMax, latMin));
        gntLog.push_back(imem_addr);
      end
    end
    if (rst) begin
      expPc = RPC;
    end else begin
      if (if_valid && if_ready) begin
        expQ.push_back(expPc);
        xfers++;
        expPc = expPc + 32'd4;
      end
      if (redirect) expPc = redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic waitGnt(output logic [31:0] addr);
    bit hit = 1'b0;
    int n = 0;
    addr = '0;
    while (!hit && n < 60) begin
      cycle();
      n++;
      if (gntNow) begin
        hit  = 1'b1;
        addr = gntLog[$];
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_grant timeout actual=none required=grant");
    end
  endtask

  task automatic waitValid();
    bit hit = 1'b0;
    int n = 0;
    while (!hit && n < 60) begin
      cycle();
      n++;
      if (if_valid) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_valid timeout actual=0 required=1");
    end
  endtask

  // Monitor: every accepted instruction is compared against the scoreboard.
  int          cyc = 0;
  int          lastX = -1;
  bit          fastPhase = 1'b0;
  logic [31:0] expE;
  logic [31:0] expW;

  always @(negedge clk) begin
    cyc++;
    if (!rst && if_valid && if_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transfer actual=%h required=none", if_pc);
      end else begin
        expE = expQ.pop_front();
        expW = memWord(expE);
        check32("if_pc", if_pc, expE);
        check32("if_instr", if_instr, expW);
        check32("ins_opCode", {26'd0, ins_opCode}, {26'd0, expW[31:26]});
        check32("if_pc_plus4", if_pc_plus4, expE + 32'd4);
        if (fastPhase) begin
          if (lastX >= 0) check32("throughput_gap", 32'(cyc - lastX), 32'd3);
          lastX = cyc;
        end
      end
    end
  end

  logic [31:0] a;

  initial begin
    repeat (3) cycle();
    check32("rst_if_valid", 32'(if_valid), 32'd0);
    check32("rst_if_instr", if_instr, 32'd0);
    check32("rst_if_pc", if_pc, RPC);
    check32("rst_if_pc_plus4", if_pc_plus4, RPC + 32'd4);
    check32("rst_opcode", 32'(ins_opCode), 32'd0);
`ifdef IF_ALIGN_FAULT_EN
    check32("rst_if_fault", 32'(if_fault), 32'd0);
`endif

    // Best case: grant always, one-cycle latency, decode always ready.
    gntLog.delete();
    rstReq    = 1'b0;
    fastPhase = 1'b1;
    repeat (3) cycle();
    check32("first_valid", 32'(if_valid), 32'd1);
    check32("first_opcode", 32'(ins_opCode), 32'(6'b100011));
    repeat (9) cycle();
    fastPhase = 1'b0;
    check32("req_count", 32'(gntLog.size() >= 3), 32'd1);
    if (gntLog.size() >= 3) begin
      check32("req0", gntLog[0], RPC);
      check32("req1", gntLog[1], RPC + 32'd4);
      check32("req2", gntLog[2], RPC + 32'd8);
    end

    // Backpressure: held instruction must stay put and no fetch may issue.
    readyMode = 2;
    waitValid();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check32("bp_valid", 32'(if_valid), 32'd1);
      check32("bp_pc", if_pc, expPc);
      check32("bp_instr", if_instr, memWord(expPc));
      check32("bp_no_req", 32'(imem_req), 32'd0);
    end
    readyMode = 1;
    waitGnt(a);
    check32("bp_next_req", a, expPc);

    // Redirect while waiting; the owed response carries poison data.
    latMin = 3;
    latMax = 3;
    waitGnt(a);
    forceDead   = 1'b1;
    redirReq    = 1'b1;
    redirTarget = 32'h0000_0100;
    cycle();
    redirReq = 1'b0;
    latMin   = 1;
    latMax   = 1;
    waitGnt(a);
    check32("wait_redirect_req", a, 32'h0000_0100);

    // Redirect coinciding with a transfer.
    readyMode = 2;
    waitValid();
    readyMode   = 1;
    redirReq    = 1'b1;
    redirTarget = 32'h0000_0040;
    cycle();
    redirReq = 1'b0;
    waitGnt(a);
    check32("hold_redirect_req", a, 32'h0000_0040);

    // PC wrap at the top of the address space.
    redirReq    = 1'b1;
    redirTarget = 32'hFFFF_FFFC;
    cycle();
    redirReq = 1'b0;
    waitGnt(a);
    check32("wrap_req_top", a, 32'hFFFF_FFFC);
    waitGnt(a);
    check32("wrap_req_zero", a, 32'h0000_0000);

    // Misaligned redirect target.
    redirReq    = 1'b1;
    redirTarget = 32'h0000_0203;
    cycle();
    redirReq = 1'b0;
`ifdef IF_ALIGN_FAULT_EN
    for (int i = 0; i < 4; i++) begin
      cycle();
      check32("fault_flag", 32'(if_fault), 32'd1);
      check32("fault_no_req", 32'(imem_req), 32'd0);
      check32("fault_no_valid", 32'(if_valid), 32'd0);
    end
    redirReq    = 1'b1;
    redirTarget = 32'h0000_0200;
    cycle();
    redirReq = 1'b0;
    cycle();
    check32("fault_cleared", 32'(if_fault), 32'd0);
`endif
    waitGnt(a);
    check32("align_req", a, 32'h0000_0200);

    // Reset while waiting; the stale response lands just after reset.
    latMin = 2;
    latMax = 2;
    waitGnt(a);
    rstReq = 1'b1;
    cycle();
    rstReq = 1'b0;
    waitGnt(a);
    check32("post_rst_req", a, RPC);
    latMin = 1;
    latMax = 4;

    // Randomized traffic with redirects.
    gntPct    = 60;
    readyMode = 0;
    for (int i = 0; i < 3000; i++) begin
      redirReq = ($urandom_range(99) < 4);
      redirTarget = 32'($urandom_range(1023));
      if ($urandom_range(9) == 0) redirTarget = 32'hFFFF_FFE0 | redirTarget[4:0];
`ifdef IF_ALIGN_FAULT_EN
      redirTarget = redirTarget & 32'hFFFF_FFFC;
`endif
      cycle();
    end
    redirReq  = 1'b0;
    readyMode = 1;
    repeat (20) cycle();
    @(negedge clk);
    #1;
    check32("progress", 32'(xfers > 100), 32'd1);
    check32("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
